tap_controller: RTL and testbench

// - IEEE 1149.1-style TAP controller. It is the control end of the DR interface that data_reg consumes.
// - Decodes TMS into the 16-state TAP FSM and drives Capture_DR/Shift_DR/Update_DR plus the IR equivalents.
// - Holds the instruction register (IR), decodes tdr_select, and muxes the serial TDO from IR, BYPASS, IDCODE or the user DR.

---
 rtl/tap_if.sv | 36 +++
 rtl/tap_controller.sv | 200 ++++++++++++++++++++
 tb/tb_tap_controller.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_if.sv
// TAP pin and strobe bundle between the TAP controller (master) and its consumers (slave).
// The width of IR_out follows IR_length.
interface tap_if #(
  parameter int unsigned IR_length = 4
) ();
  logic                 TMS;
  logic                 TDI;
  logic                 dr_TDO;
  logic                 TDO;
  logic                 TDO_en;
  logic                 tdr_select;
  logic                 Capture_DR;
  logic                 Shift_DR;
  logic                 Update_DR;
  logic                 Capture_IR;
  logic                 Shift_IR;
  logic                 Update_IR;
  logic [IR_length-1:0] IR_out;
  logic [3:0]           state_out;

  modport master (
    input  TMS, TDI, dr_TDO,
    output TDO, TDO_en, tdr_select,
    output Capture_DR, Shift_DR, Update_DR,
    output Capture_IR, Shift_IR, Update_IR,
    output IR_out, state_out
  );

  modport slave (
    output TMS, TDI, dr_TDO,
    input  TDO, TDO_en, tdr_select,
    input  Capture_DR, Shift_DR, Update_DR,
    input  Capture_IR, Shift_IR, Update_IR,
    input  IR_out, state_out
  );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register, BYPASS and TDO mux.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register and make IDC_OPCODE the reset opcode.
module tap_controller #(
  parameter int unsigned          IR_length  = 4,
  parameter logic [IR_length-1:0] TDR_OPCODE = IR_length'(4'b0010),
  parameter logic [IR_length-1:0] IDC_OPCODE = IR_length'(4'b0001),
  parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001
) (
  input logic TCK,
  input logic TRST_n,
  tap_if.master bus
);

  typedef enum logic [3:0] {
    StTlr   = 4'hF,
    StRti   = 4'hC,
    StSelDr = 4'h7,
    StCapDr = 4'h6,
    StShDr  = 4'h2,
    StEx1Dr = 4'h1,
    StPaDr  = 4'h3,
    StEx2Dr = 4'h0,
    StUpdDr = 4'h5,
    StSelIr = 4'h4,
    StCapIr = 4'hE,
    StShIr  = 4'hA,
    StEx1Ir = 4'h9,
    StPaIr  = 4'hB,
    StEx2Ir = 4'h8,
    StUpdIr = 4'hD
  } tap_state_e;

`ifdef TAP_IDCODE_EN
  localparam logic [IR_length-1:0] ResetOpcode = IDC_OPCODE;
`else
  localparam logic [IR_length-1:0] ResetOpcode = {IR_length{1'b1}};
`endif

  // Elaboration-time sanity checks on the configuration.
  if (IR_length < 2) begin : g_bad_ir_length
    $error("tap_controller: IR_length must be at least 2");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
    $error("tap_controller: IDCODE_VAL bit 0 must be 1");
  end
  if (IDC_OPCODE == TDR_OPCODE) begin : g_opcode_clash
    $error("tap_controller: IDC_OPCODE and TDR_OPCODE must differ");
  end

  tap_state_e           state_q, state_d;
  logic [IR_length-1:0] ir_sr_q, ir_sr_d;
  logic [IR_length-1:0] ir_q, ir_d;
  logic                 bypass_q, bypass_d;
  logic                 tdo_q, tdo_d;
  logic                 tdo_en_q, tdo_en_d;
  logic                 tdr_sel;
  logic                 dr_src;

  // TAP state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StTlr:   state_d = bus.TMS ? StTlr   : StRti;
      StRti:   state_d = bus.TMS ? StSelDr : StRti;
      StSelDr: state_d = bus.TMS ? StSelIr : StCapDr;
      StCapDr: state_d = bus.TMS ? StEx1Dr : StShDr;
      StShDr:  state_d = bus.TMS ? StEx1Dr : StShDr;
      StEx1Dr: state_d = bus.TMS ? StUpdDr : StPaDr;
      StPaDr:  state_d = bus.TMS ? StEx2Dr : StPaDr;
      StEx2Dr: state_d = bus.TMS ? StUpdDr : StShDr;
      StUpdDr: state_d = bus.TMS ? StSelDr : StRti;
      StSelIr: state_d = bus.TMS ? StTlr   : StCapIr;
      StCapIr: state_d = bus.TMS ? StEx1Ir : StShIr;
      StShIr:  state_d = bus.TMS ? StEx1Ir : StShIr;
      StEx1Ir: state_d = bus.TMS ? StUpdIr : StPaIr;
      StPaIr:  state_d = bus.TMS ? StEx2Ir : StPaIr;
      StEx2Ir: state_d = bus.TMS ? StUpdIr : StShIr;
      StUpdIr: state_d = bus.TMS ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  // IR shift/update and BYPASS; every other state holds, which covers the pause states.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_d     = ir_q;
    bypass_d = bypass_q;
    case (state_q)
      StCapIr: ir_sr_d  = IR_length'(2'b01);
      StShIr:  ir_sr_d  = {bus.TDI, ir_sr_q[IR_length-1:1]};
      StUpdIr: ir_d     = ir_sr_q;
      StCapDr: bypass_d = 1'b0;
      StShDr:  bypass_d = bus.TDI;
      default: ;
    endcase
    // Entering or staying in Test-Logic-Reset reloads the reset instruction.
    if (state_d == StTlr) begin
      ir_d = ResetOpcode;
    end
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      ir_sr_q  <= '0;
      ir_q     <= ResetOpcode;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      bypass_q <= bypass_d;
    end
  end

  assign tdr_sel = (ir_q == TDR_OPCODE);

`ifdef TAP_IDCODE_EN
  logic        idc_sel;
  logic [31:0] idcode_q, idcode_d;

  assign idc_sel = (ir_q == IDC_OPCODE);

  always_comb begin
    idcode_d = idcode_q;
    if (idc_sel && (state_q == StCapDr)) begin
      idcode_d = IDCODE_VAL;
    end else if (idc_sel && (state_q == StShDr)) begin
      idcode_d = {bus.TDI, idcode_q[31:1]};
    end
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      idcode_q <= '0;
    end else begin
      idcode_q <= idcode_d;
    end
  end
`endif

  // Serial source for SH_DR; unknown opcodes fall through to BYPASS.
  always_comb begin
    dr_src = bypass_q;
    if (tdr_sel) begin
      dr_src = bus.dr_TDO;
    end
`ifdef TAP_IDCODE_EN
    else if (idc_sel) begin
      dr_src = idcode_q[0];
    end
`endif
  end

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    case (state_q)
      StShIr: begin
        tdo_d    = ir_sr_q[0];
        tdo_en_d = 1'b1;
      end
      StShDr: begin
        tdo_d    = dr_src;
        tdo_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  // TDO launches on the falling edge so the far end can sample it on the next rising edge.
  always_ff @(negedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign bus.TDO        = tdo_q;
  assign bus.TDO_en     = tdo_en_q;
  assign bus.tdr_select = tdr_sel;
  assign bus.IR_out     = ir_q;
  assign bus.state_out  = state_q;
  assign bus.Capture_DR = (state_q == StCapDr);
  assign bus.Shift_DR   = (state_q == StShDr);
  assign bus.Update_DR  = (state_q == StUpdDr);
  assign bus.Capture_IR = (state_q == StCapIr);
  assign bus.Shift_IR   = (state_q == StShIr);
  assign bus.Update_IR  = (state_q == StUpdIr);

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed scenarios plus random TMS/TDI traffic
// checked against a table-driven reference model of the TAP.
module tb_tap_controller;

  localparam int unsigned IRL = 4;
  localparam logic [3:0] TDR_OP = 4'b0010;
  localparam logic [3:0] IDC_OP = 4'b0001;
  localparam logic [31:0] IDC_VAL = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0] RESET_OP = IDC_OP;
  localparam bit IDC_EN = 1'b1;
`else
  localparam logic [3:0] RESET_OP = 4'b1111;
  localparam bit IDC_EN = 1'b0;
`endif

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PADR = 4'h3, S_EX2DR = 4'h0;
  localparam logic [3:0] S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA;
  localparam logic [3:0] S_EX1IR = 4'h9, S_PAIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

  logic TCK;
  logic TRST_n;
  tap_if #(.IR_length(IRL)) bus ();

  tap_controller #(
    .IR_length (IRL),
    .TDR_OPCODE(TDR_OP),
    .IDC_OPCODE(IDC_OP),
    .IDCODE_VAL(IDC_VAL)
  ) dut (
    .TCK   (TCK),
    .TRST_n(TRST_n),
    .bus   (bus)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];
  logic [3:0]  m_state;
  logic [3:0]  m_ir;
  logic [3:0]  m_irsr;
  logic        m_byp;
  logic [31:0] m_idc;
  logic        m_tdo;
  logic        m_en;

  task automatic set_tr(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic init_tables();
    set_tr(S_TLR, S_RTI, S_TLR);       set_tr(S_RTI, S_RTI, S_SELDR);
    set_tr(S_SELDR, S_CAPDR, S_SELIR); set_tr(S_SELIR, S_CAPIR, S_TLR);
    set_tr(S_CAPDR, S_SHDR, S_EX1DR);  set_tr(S_SHDR, S_SHDR, S_EX1DR);
    set_tr(S_EX1DR, S_PADR, S_UPDDR);  set_tr(S_PADR, S_PADR, S_EX2DR);
    set_tr(S_EX2DR, S_SHDR, S_UPDDR);  set_tr(S_UPDDR, S_RTI, S_SELDR);
    set_tr(S_CAPIR, S_SHIR, S_EX1IR);  set_tr(S_SHIR, S_SHIR, S_EX1IR);
    set_tr(S_EX1IR, S_PAIR, S_UPDIR);  set_tr(S_PAIR, S_PAIR, S_EX2IR);
    set_tr(S_EX2IR, S_SHIR, S_UPDIR);  set_tr(S_UPDIR, S_RTI, S_SELDR);
  endtask

  task automatic model_reset();
    m_state = S_TLR;
    m_ir    = RESET_OP;
    m_irsr  = '0;
    m_byp   = 1'b0;
    m_idc   = '0;
    m_tdo   = 1'b0;
    m_en    = 1'b0;
  endtask

  task automatic model_posedge(input logic tms, input logic tdi);
    logic [3:0] cur;
    cur = m_state;
    if (cur == S_CAPIR) m_irsr = 4'b0001;
    if (cur == S_SHIR)  m_irsr = {tdi, m_irsr[3:1]};
    if (cur == S_UPDIR) m_ir = m_irsr;
    if (cur == S_CAPDR) begin
      m_byp = 1'b0;
      if (IDC_EN && m_ir == IDC_OP) m_idc = IDC_VAL;
    end
    if (cur == S_SHDR) begin
      m_byp = tdi;
      if (IDC_EN && m_ir == IDC_OP) m_idc = {tdi, m_idc[31:1]};
    end
    m_state = tms ? nxt1[cur] : nxt0[cur];
    if (m_state == S_TLR) m_ir = RESET_OP;
  endtask

  task automatic model_negedge(input logic dr);
    m_tdo = 1'b0;
    m_en  = 1'b0;
    if (m_state == S_SHIR) begin
      m_tdo = m_irsr[0];
      m_en  = 1'b1;
    end else if (m_state == S_SHDR) begin
      m_en = 1'b1;
      if (m_ir == TDR_OP) m_tdo = dr;
      else if (IDC_EN && m_ir == IDC_OP) m_tdo = m_idc[0];
      else m_tdo = m_byp;
    end
  endtask

  function automatic logic [5:0] exp_strobes(input logic [3:0] s);
    return {s == S_CAPDR, s == S_SHDR, s == S_UPDDR, s == S_CAPIR, s == S_SHIR, s == S_UPDIR};
  endfunction

  function automatic logic [5:0] dut_strobes();
    return {bus.Capture_DR, bus.Shift_DR, bus.Update_DR,
            bus.Capture_IR, bus.Shift_IR, bus.Update_IR};
  endfunction

  // One TCK cycle; returns just after the falling edge with the model in step.
  task automatic tick(input logic tms, input logic tdi, input logic dr);
    bus.TMS = tms;
    bus.TDI = tdi;
    bus.dr_TDO = dr;
    @(posedge TCK);
    #1;
    model_posedge(tms, tdi);
    @(negedge TCK);
    #1;
    model_negedge(dr);
  endtask

  task automatic load_ir(input logic [3:0] op);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, op[i], 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges; TMS held high so TLR is kept.
  task automatic pulse_reset();
    bus.TMS = 1'b1;
    #2;
    TRST_n = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    TRST_n = 1'b1;
    @(negedge TCK);
    #1;
  endtask

  task automatic test_reset();
    TRST_n = 1'b0;
    bus.TMS = 1'b1;
    bus.TDI = 1'b0;
    bus.dr_TDO = 1'b0;
    #12;
    model_reset();
    n_checks++;
    if (bus.state_out !== 4'hF) begin
      n_fail++; $display("FAIL reset_state got %h expected F", bus.state_out);
    end
    n_checks++;
    if (dut_strobes() !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b expected 000000", dut_strobes());
    end
    n_checks++;
    if (bus.TDO_en !== 1'b0 || bus.TDO !== 1'b0) begin
      n_fail++; $display("FAIL reset_tdo got en=%b tdo=%b expected 0 0", bus.TDO_en, bus.TDO);
    end
    n_checks++;
    if (bus.IR_out !== RESET_OP) begin
      n_fail++; $display("FAIL reset_ir got %b expected %b", bus.IR_out, RESET_OP);
    end
    release_reset();
  endtask

  task automatic test_tlr_from_shdr();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.state_out !== S_SHDR) begin
      n_fail++; $display("FAIL reach_shdr got %h expected 2", bus.state_out);
    end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.state_out !== S_TLR) begin
      n_fail++; $display("FAIL tms5_tlr got %h expected F", bus.state_out);
    end
  endtask

  task automatic test_ir_load();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.Capture_IR !== 1'b1) begin
      n_fail++; $display("FAIL capture_ir got %b expected 1", bus.Capture_IR);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.TDO !== 1'b1 || bus.TDO_en !== 1'b1) begin
      n_fail++; $display("FAIL ir_cap_bit0 got tdo=%b en=%b expected 1 1", bus.TDO, bus.TDO_en);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.TDO !== 1'b0) begin
      n_fail++; $display("FAIL ir_cap_bit1 got %b expected 0", bus.TDO);
    end
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.IR_out !== RESET_OP) begin
      n_fail++; $display("FAIL ir_mid_shift got %b expected %b", bus.IR_out, RESET_OP);
    end
    tick(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.Update_IR !== 1'b1) begin
      n_fail++; $display("FAIL update_ir got %b expected 1", bus.Update_IR);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.IR_out !== 4'b0010 || bus.tdr_select !== 1'b1) begin
      n_fail++; $display("FAIL ir_loaded got ir=%b sel=%b expected 0010 1",
                         bus.IR_out, bus.tdr_select);
    end
  endtask

  task automatic test_dr_path();
    logic [9:0] seq;
    int cap_cnt, sh_cnt, upd_cnt;
    logic d;
    seq = 10'b0110000001;  // bit i is TMS for tick i: SEL CAP SHx5 EX1 UPD RTI
    cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      d = 1'($urandom_range(0, 1));
      tick(seq[i], 1'b0, d);
      cap_cnt += int'(bus.Capture_DR);
      sh_cnt  += int'(bus.Shift_DR);
      upd_cnt += int'(bus.Update_DR);
      if (bus.Shift_DR === 1'b1) begin
        n_checks++;
        if (bus.TDO !== d || bus.TDO_en !== 1'b1) begin
          n_fail++; $display("FAIL dr_tdo tick %0d got tdo=%b en=%b expected %b 1",
                             i, bus.TDO, bus.TDO_en, d);
        end
      end
    end
    n_checks++;
    if (cap_cnt != 1 || sh_cnt != 5 || upd_cnt != 1) begin
      n_fail++; $display("FAIL dr_strobe_counts got cap=%0d sh=%0d upd=%0d expected 1 5 1",
                         cap_cnt, sh_cnt, upd_cnt);
    end
  endtask

  task automatic test_bypass();
    logic [8:0] tms_seq;
    logic [8:0] tdi_seq;
    logic [3:0] obs;
    load_ir(4'b1111);
    tms_seq = 9'b011000001;
    tdi_seq = 9'b001101000;
    obs = '0;
    for (int i = 0; i < 9; i++) begin
      tick(tms_seq[i], tdi_seq[i], 1'b1);
      if (i >= 2 && i <= 5) obs[i-2] = bus.TDO;
    end
    n_checks++;
    if (obs !== 4'b1010) begin
      n_fail++; $display("FAIL bypass_seq got %b expected 1010 (first bit at LSB)", obs);
    end
  endtask

  task automatic test_pause();
    logic [2:0] obs;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.state_out !== S_PAIR || bus.TDO_en !== 1'b0 || bus.IR_out !== 4'b1111) begin
      n_fail++; $display("FAIL pause_ir got st=%h en=%b ir=%b expected B 0 1111",
                         bus.state_out, bus.TDO_en, bus.IR_out);
    end
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    obs[0] = bus.TDO;
    tick(1'b0, 1'b0, 1'b0);
    obs[1] = bus.TDO;
    tick(1'b0, 1'b0, 1'b0);
    obs[2] = bus.TDO;
    n_checks++;
    if (obs !== 3'b100 || bus.IR_out !== 4'b1111) begin
      n_fail++; $display("FAIL pause_resume got tdo=%b ir=%b expected 100 1111", obs, bus.IR_out);
    end
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.IR_out !== 4'b0000 || bus.IR_out !== m_ir) begin
      n_fail++; $display("FAIL pause_update got %b expected 0000", bus.IR_out);
    end
  endtask

  task automatic test_trst_abort();
    load_ir(TDR_OP);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    pulse_reset();
    n_checks++;
    if (bus.state_out !== S_TLR || bus.IR_out !== RESET_OP || bus.tdr_select !== 1'b0
        || bus.TDO_en !== 1'b0) begin
      n_fail++; $display("FAIL trst_abort got st=%h ir=%b sel=%b en=%b expected F %b 0 0",
                         bus.state_out, bus.IR_out, bus.tdr_select, bus.TDO_en, RESET_OP);
    end
    release_reset();
  endtask

`ifdef TAP_IDCODE_EN
  task automatic test_idcode();
    logic [31:0] obs;
    pulse_reset();
    release_reset();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    obs[0] = bus.TDO;
    for (int i = 1; i < 32; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      obs[i] = bus.TDO;
    end
    n_checks++;
    if (obs !== IDC_VAL) begin
      n_fail++; $display("FAIL idcode got %h expected %h", obs, IDC_VAL);
    end
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic tms, tdi, dr;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
        release_reset();
      end
      tms = ($urandom_range(0, 99) < 35);
      tdi = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      tick(tms, tdi, dr);
      n_checks++;
      if (bus.state_out !== m_state) begin
        n_fail++; $display("FAIL rnd_state cycle %0d got %h expected %h", c, bus.state_out, m_state);
      end
      n_checks++;
      if (bus.IR_out !== m_ir || bus.tdr_select !== (m_ir == TDR_OP)) begin
        n_fail++; $display("FAIL rnd_ir cycle %0d got %b/%b expected %b/%b",
                           c, bus.IR_out, bus.tdr_select, m_ir, m_ir == TDR_OP);
      end
      n_checks++;
      if (dut_strobes() !== exp_strobes(m_state)) begin
        n_fail++; $display("FAIL rnd_strobes cycle %0d got %b expected %b",
                           c, dut_strobes(), exp_strobes(m_state));
      end
      n_checks++;
      if (bus.TDO !== m_tdo || bus.TDO_en !== m_en) begin
        n_fail++; $display("FAIL rnd_tdo cycle %0d got %b/%b expected %b/%b",
                           c, bus.TDO, bus.TDO_en, m_tdo, m_en);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_tables();
    model_reset();
    test_reset();
    test_tlr_from_shdr();
    test_ir_load();
    test_dr_path();
    test_bypass();
    test_pause();
    test_trst_abort();
`ifdef TAP_IDCODE_EN
    test_idcode();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
